// File: rtl/banked_ram16.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram16
// Description : Byte-addressed RAM with a 16-bit data path, built from an
//               even-address bank and an odd-address bank. It supports 8- or
//               16-bit little-endian accesses at any alignment; a misaligned
//               word is split across the two banks. It also provides a
//               per-byte range check, a write-first bypass and an optional
//               post-reset fill sequencer. Read latency is one cycle.
// Ports       : clk        - clock, rising edge
//               reset_n    - asynchronous active-low reset
//               read_addr  - byte address A of the read
//               read_wide  - 1: bytes A, A+1; 0: byte A only
//               read_data  - [7:0]=byte A, [15:8]=byte A+1, one cycle later
//               read_hit   - every requested byte was in range
//               write_addr - byte address A of the write
//               write_data - [7:0] to byte A, [15:8] to byte A+1
//               write_wide - 1: 16-bit write; 0: 8-bit write
//               write_en   - write strobe
//               busy       - fill in progress, host accesses are ignored
// Revision    : 1.0 - initial release
// ============================================================================
module banked_ram16 #(
  parameter int unsigned SIZE  = 1024,
  parameter int unsigned TOP   = 32'h4000,
  parameter bit          CLEAR = 1'b1,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] read_addr,
  input  logic        read_wide,
  output logic [15:0] read_data,
  output logic        read_hit,
  input  logic [15:0] write_addr,
  input  logic [15:0] write_data,
  input  logic        write_wide,
  input  logic        write_en,
  output logic        busy
);

  localparam int              c_iw       = $clog2(SIZE) - 1;
  localparam int              c_depth    = SIZE / 2;
  localparam logic [16:0]     c_base     = 17'(TOP - SIZE);
  localparam logic [16:0]     c_top      = 17'(TOP);
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(c_depth - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [c_iw-1:0] r_fill_idx;
  logic [c_iw-1:0] w_fill_idx_next;

  // Banks: even bank holds even byte addresses, odd bank holds odd ones.
  logic [7:0]      r_mem_e [0:c_depth-1];
  logic [7:0]      r_mem_o [0:c_depth-1];

  logic            w_we_e, w_we_o;
  logic [c_iw-1:0] w_widx_e, w_widx_o;
  logic [7:0]      w_wd_e, w_wd_o;
  logic [c_iw-1:0] w_ridx_e, w_ridx_o;
  logic [7:0]      r_rd_e, r_rd_o;

  logic            r_a0, r_wide, r_in0, r_in1;
  logic [15:0]     w_wa1, w_ra1;
  logic            w_run, w_wr0_ok, w_wr1_ok;
  logic [7:0]      w_lane0, w_lane1;

  function automatic logic in_range(input logic [15:0] a);
    return ({1'b0, a} >= c_base) && ({1'b0, a} < c_top);
  endfunction

  // Bank index of a byte address; out-of-range addresses give a harmless
  // in-bounds index because their data is masked or their write suppressed.
  function automatic logic [c_iw-1:0] bank_idx(input logic [15:0] a);
    return c_iw'((a - c_base[15:0]) >> 1);
  endfunction

  // 16-bit address arithmetic: A+1 wraps at 16'hFFFF.
  assign w_wa1    = write_addr + 16'd1;
  assign w_ra1    = read_addr + 16'd1;
  assign w_run    = (r_state == ST_RUN);
  assign w_wr0_ok = write_en && in_range(write_addr);
  assign w_wr1_ok = write_en && write_wide && in_range(w_wa1);

  // A and A+1 always have opposite parity, so each bank sees at most one
  // byte per cycle; the parity of A picks which byte lands in which bank.
  always_comb begin
    w_we_e   = 1'b0;
    w_we_o   = 1'b0;
    w_widx_e = '0;
    w_widx_o = '0;
    w_wd_e   = 8'h00;
    w_wd_o   = 8'h00;
    if (!w_run) begin
      w_we_e   = 1'b1;
      w_we_o   = 1'b1;
      w_widx_e = r_fill_idx;
      w_widx_o = r_fill_idx;
      w_wd_e   = FILL;
      w_wd_o   = FILL;
    end else if (!write_addr[0]) begin
      w_we_e   = w_wr0_ok;
      w_widx_e = bank_idx(write_addr);
      w_wd_e   = write_data[7:0];
      w_we_o   = w_wr1_ok;
      w_widx_o = bank_idx(w_wa1);
      w_wd_o   = write_data[15:8];
    end else begin
      w_we_o   = w_wr0_ok;
      w_widx_o = bank_idx(write_addr);
      w_wd_o   = write_data[7:0];
      w_we_e   = w_wr1_ok;
      w_widx_e = bank_idx(w_wa1);
      w_wd_e   = write_data[15:8];
    end
  end

  always_comb begin
    if (!read_addr[0]) begin
      w_ridx_e = bank_idx(read_addr);
      w_ridx_o = bank_idx(w_ra1);
    end else begin
      w_ridx_o = bank_idx(read_addr);
      w_ridx_e = bank_idx(w_ra1);
    end
  end

  // Storage is not reset. A same-index write in the same cycle is forwarded
  // to the read register, which gives write-first behaviour per byte.
  always_ff @(posedge clk) begin
    if (w_we_e) r_mem_e[w_widx_e] <= w_wd_e;
    if (w_we_o) r_mem_o[w_widx_o] <= w_wd_o;
    r_rd_e <= (w_we_e && (w_widx_e == w_ridx_e)) ? w_wd_e : r_mem_e[w_ridx_e];
    r_rd_o <= (w_we_o && (w_widx_o == w_ridx_o)) ? w_wd_o : r_mem_o[w_ridx_o];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= CLEAR ? ST_FILL : ST_RUN;
      r_fill_idx <= '0;
      r_a0       <= 1'b0;
      r_wide     <= 1'b0;
      r_in0      <= 1'b0;
      r_in1      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill_idx <= w_fill_idx_next;
      r_a0       <= read_addr[0];
      r_wide     <= read_wide;
      // Reads during fill are dropped by clearing both byte flags.
      r_in0      <= w_run && in_range(read_addr);
      r_in1      <= w_run && read_wide && in_range(w_ra1);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_idx_next = r_fill_idx;
    busy            = 1'b0;
    case (r_state)
      ST_FILL: begin
        busy            = 1'b1;
        w_fill_idx_next = r_fill_idx + c_iw'(1);
        if (r_fill_idx == c_last_idx) begin
          w_state_next    = ST_RUN;
          w_fill_idx_next = '0;
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Lane steering by the registered parity of A.
  assign w_lane0   = r_a0 ? r_rd_o : r_rd_e;
  assign w_lane1   = r_a0 ? r_rd_e : r_rd_o;
  assign read_data = {(r_in1 ? w_lane1 : 8'h00), (r_in0 ? w_lane0 : 8'h00)};
  assign read_hit  = r_in0 && (!r_wide || r_in1);

endmodule
`default_nettype wire
